// File: rtl/boot_loader.sv
// Boot loader: gathers a little-endian byte stream into a word image while the cpu
// is held in reset, then serves that image on the shared data bus during the cpu's boot sweep.
module boot_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 cpu_rst,
  input  logic                 cpu_boot,
  input  logic [ADDR_SIZE-1:0] addr_bus,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  output logic                 done,
  output logic                 err
);

  // Byte stream handshake: a byte moves on a rising edge where rx_valid and rx_ready
  // are both high; rx_ready is high only in LOAD, so later bytes stay with the sender.
  localparam int IMG_WORDS = 2 ** (ADDR_SIZE - 1);

  typedef enum logic [1:0] {LOAD, RELEASE, STREAM, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_SIZE-1:0]   byte_cnt;
  logic [7:0]             stage;
  logic [WORD_SIZE-1:0]   img_buf [IMG_WORDS];
  logic                   seen_boot;
  logic                   first_cyc;
  logic                   err_set;
  logic                   take;
  logic                   last_byte;

  assign take      = (state == LOAD) && rx_valid;
  assign last_byte = (byte_cnt == '1);

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    cpu_rst   = 1'b0;
    done      = 1'b0;
    err_set   = 1'b0;
    case (state)
      LOAD: begin
        rx_ready = 1'b1;
        cpu_rst  = 1'b1;
        if (rx_valid && last_byte) state_nxt = RELEASE;
      end
      RELEASE: begin
        cpu_rst   = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        // Boot must show up in the first or second STREAM cycle, else give up.
        if (seen_boot && !cpu_boot) begin
          state_nxt = DONE;
        end else if (!seen_boot && !cpu_boot && !first_cyc) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      byte_cnt  <= '0;
      err       <= 1'b0;
      seen_boot <= 1'b0;
      first_cyc <= 1'b0;
    end else begin
      state     <= state_nxt;
      first_cyc <= (state == RELEASE);
      if (take && !last_byte) byte_cnt <= byte_cnt + 1'b1;
      if (err_set) err <= 1'b1;
      if (state == STREAM && cpu_boot) seen_boot <= 1'b1;
    end
  end

  // Image storage is not reset; a reload simply overwrites it.
  always_ff @(posedge clk) begin
    if (!rst && take) begin
      if (!byte_cnt[0]) stage <= rx_data;
      else img_buf[byte_cnt[ADDR_SIZE-1:1]] <= {rx_data, stage};
    end
  end

  assign data_bus = (state == STREAM && cpu_boot) ? img_buf[addr_bus[ADDR_SIZE-1:1]] : 'z;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a cpu/memory model sweeps the bus after release and the
// loaded memory is compared with the image bytes the bench sent.
module tb_boot_loader;
  localparam int AW = 4;
  localparam int NW = 8;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          cpu_boot = 1'b0;
  logic          cpu_drive = 1'b1;
  logic [15:0]   cpu_val = 16'h0000;
  logic [AW-1:0] addr_bus = '0;
  logic          rx_ready, cpu_rst, done, err;
  wire  [15:0]   data_bus;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  img [NB];
  logic [15:0] mem [NW];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  // The bench-side cpu drives the bus whenever it is not reading it, so any loader
  // drive outside a boot read shows up as a value other than cpu_val.
  assign data_bus = cpu_drive ? cpu_val : 16'hzzzz;

  boot_loader #(.WORD_SIZE(16), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_rst(cpu_rst), .cpu_boot(cpu_boot), .addr_bus(addr_bus), .data_bus(data_bus),
    .done(done), .err(err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; cpu_boot = 1'b0; cpu_drive = 1'b1; cpu_val = 16'h0000;
    addr_bus = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) mem[i] = 16'hDEAD;
  endtask

  task automatic random_image();
    for (int w = 0; w < NW; w++) begin
      do begin
        img[2*w]   = 8'($urandom);
        img[2*w+1] = 8'($urandom);
      end while ({img[2*w+1], img[2*w]} == 16'h0000);
    end
  endtask

  // Sends image bytes until n have been accepted; mode 0 continuous, 1 toggling, 2 random.
  task automatic feed(input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    logic [7:0] lo = 8'h00;
    while (acc < n && cyc < 400) begin
      n_checks++;
      if (rx_ready !== 1'b1 || cpu_rst !== 1'b1) begin
        n_fail++;
        $display("FAIL load_flags: rx_ready=%b cpu_rst=%b want 1 1 (byte %0d)", rx_ready, cpu_rst, acc);
      end
      rx_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      rx_data  = img[acc];
      @(negedge clk);
      if (rx_valid) begin
        if (acc % 2 == 0) lo = rx_data;
        else exp_q.push_back({rx_data, lo});
        acc++;
      end
      cyc++;
    end
    rx_valid = 1'b0;
    n_checks++;
    if (acc != n) begin
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d want %0d", acc, n);
    end
    if (n == NB) begin
      n_checks++;
      if (rx_ready !== 1'b0 || cpu_rst !== 1'b1 || data_bus !== 16'h0000) begin
        n_fail++;
        $display("FAIL release: rx_ready=%b cpu_rst=%b bus=%h want 0 1 0000", rx_ready, cpu_rst, data_bus);
      end
      @(negedge clk);
      n_checks++;
      if (rx_ready !== 1'b0 || cpu_rst !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_entry: rx_ready=%b cpu_rst=%b done=%b want 0 0 0", rx_ready, cpu_rst, done);
      end
    end
  endtask

  // Cpu boot sweep starting in the first STREAM cycle; stop_word >= 0 asserts rst there.
  task automatic cpu_sweep(input int delay, input int stop_word);
    logic [15:0] exp;
    if (delay > 0) begin
      #1;
      n_checks++;
      if (data_bus !== 16'h0000) begin
        n_fail++;
        $display("FAIL stream_idle: bus=%h want 0000", data_bus);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NW; i++) begin
      cpu_drive = 1'b0; cpu_boot = 1'b1; addr_bus = AW'(2 * i);
      #1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_checks++;
      if (data_bus !== exp || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_word: addr=%0d bus=%h done=%b want %h 0", 2 * i, data_bus, done, exp);
      end
      mem[i] = data_bus;
      if (i == stop_word) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_drive = 1'b1; cpu_val = 16'h0000;
        #1;
        n_checks++;
        if (data_bus !== 16'h0000 || cpu_rst !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_stream: bus=%h cpu_rst=%b rx_ready=%b done=%b want 0000 1 1 0",
                   data_bus, cpu_rst, rx_ready, done);
        end
        cpu_boot = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    cpu_boot = 1'b0; cpu_drive = 1'b1; cpu_val = 16'h0000; addr_bus = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0 || data_bus !== 16'h0000) begin
      n_fail++;
      $display("FAIL boot_done: done=%b err=%b cpu_rst=%b bus=%h want 1 0 0 0000", done, err, cpu_rst, data_bus);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || data_bus !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: rx_ready=%b cpu_rst=%b done=%b err=%b bus=%h want 1 1 0 0 0000",
               rx_ready, cpu_rst, done, err, data_bus);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_load_stream(input int mode, input int delay);
    do_reset();
    feed(NB, mode);
    cpu_sweep(delay, -1);
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== {img[2*i+1], img[2*i]}) begin
        n_fail++;
        $display("FAIL mem_word: mode=%0d word=%0d got %h want %h", mode, i, mem[i], {img[2*i+1], img[2*i]});
      end
    end
  endtask

  task automatic test_after_done(input logic exp_err);
    cpu_val = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      rx_valid = 1'b1; rx_data = 8'h55;
      @(negedge clk);
      n_checks++;
      if (rx_ready !== 1'b0 || done !== 1'b1 || err !== exp_err || cpu_rst !== 1'b0 || data_bus !== 16'h5A5A) begin
        n_fail++;
        $display("FAIL after_done: rx_ready=%b done=%b err=%b cpu_rst=%b bus=%h want 0 1 %b 0 5a5a",
                 rx_ready, done, err, cpu_rst, data_bus, exp_err);
      end
    end
    rx_valid = 1'b0; cpu_val = 16'h0000;
  endtask

  task automatic test_rst_mid_load();
    do_reset();
    random_image();
    feed(9, 0);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) img[i] = 8'hA0 + 8'(i);
    feed(NB, 0);
    cpu_sweep(0, -1);
    n_checks++;
    if (mem[0] !== 16'hA1A0) begin
      n_fail++;
      $display("FAIL rst_load_word0: got %h want a1a0", mem[0]);
    end
    for (int i = 1; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== {8'hA1 + 8'(2 * i), 8'hA0 + 8'(2 * i)}) begin
        n_fail++;
        $display("FAIL rst_load_word: word=%0d got %h", i, mem[i]);
      end
    end
  endtask

  task automatic test_rst_mid_stream();
    do_reset();
    random_image();
    feed(NB, 0);
    cpu_sweep(0, 3);
    random_image();
    feed(NB, 2);
    cpu_sweep(1, -1);
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== {img[2*i+1], img[2*i]}) begin
        n_fail++;
        $display("FAIL reload_word: word=%0d got %h want %h", i, mem[i], {img[2*i+1], img[2*i]});
      end
    end
  endtask

  task automatic test_no_boot();
    do_reset();
    random_image();
    feed(NB, 0);
    // Boot never arrives: two STREAM cycles are allowed, then done and err rise together.
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (done !== (c == 2) || err !== (c == 2) || cpu_rst !== 1'b0 || data_bus !== 16'h0000) begin
        n_fail++;
        $display("FAIL no_boot: cycle=%0d done=%b err=%b cpu_rst=%b bus=%h want %b %b 0 0000",
                 c, done, err, cpu_rst, data_bus, c == 2, c == 2);
      end
      if (c < 2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < NB; i++) img[i] = 8'(i);
    test_load_stream(0, 0);
    test_after_done(1'b0);
    random_image();
    test_load_stream(1, 1);
    for (int r = 0; r < 3; r++) begin
      random_image();
      test_load_stream(2, int'($urandom_range(0, 1)));
    end
    test_rst_mid_load();
    test_rst_mid_stream();
    test_no_boot();
    test_after_done(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the cpu block on its shared data/address bus.
- Collects a program image from a byte-wide valid/ready stream into an internal word buffer, holding the cpu in reset while loading.
- Releases the cpu, then drives each image word onto data_bus during the cpu's boot sweep so memory is filled.
- Goes high-Z on data_bus once boot finishes.

Parameters:
- WORD_SIZE, 16 (`WORD_SIZE), bus word width; only 16 is supported (two bytes per word).
- ADDR_SIZE, 8 (`ADDR_SIZE), byte-address width; image depth IMG_WORDS = 2**(ADDR_SIZE-1) words.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rx_data  input  8  image byte stream.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- cpu_rst  output  1  reset to cpu; high while the image is incomplete.
- cpu_boot  input  1  cpu boot flag.
- addr_bus  input  ADDR_SIZE  cpu address bus; byte address, always even during boot.
- data_bus  inout  WORD_SIZE  shared data bus; driven only in STREAM while cpu_boot=1, else 'bz.
- done  output  1  boot complete, sticky until rst.
- err  output  1  cpu failed to enter boot after release, sticky until rst.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=LOAD, byte_cnt=0, rx_ready=1, cpu_rst=1, done=0, err=0, data_bus='bz. Buffer contents are not reset.
- A byte transfer occurs on a rising edge with rx_valid & rx_ready.
- Byte order is little-endian: even byte count goes to word[7:0], odd byte count goes to word[15:8].
- Word index = byte_cnt[ADDR_SIZE-1:1].
- The buffer word is written when the high byte arrives; the low byte is held in a staging register until then.
- States:
  - LOAD: rx_ready=1, cpu_rst=1. On the transfer of byte number 2*IMG_WORDS-1 (the final byte): write the word, rx_ready<=0, go to RELEASE.
  - RELEASE: one cycle. cpu_rst stays 1, so the cpu sees at least one reset edge after the image is complete. Next state STREAM, with cpu_rst<=0.
  - STREAM: cpu_rst=0, rx_ready=0. While cpu_boot=1, data_bus = buf[addr_bus[ADDR_SIZE-1:1]] combinationally, giving zero-latency tracking of the cpu's address sweep (one word per clock, +2 bytes).
    - Exit when cpu_boot is sampled 0 after having been seen 1: go to DONE.
    - If cpu_boot is never 1 within 2 cycles of entering STREAM: err<=1, go to DONE.
  - DONE: done=1, data_bus='bz, rx_ready=0, cpu_rst=0. Stays here until rst; incoming bytes are ignored.
- Boundaries:
  - rx_valid held without rx_ready in RELEASE/STREAM/DONE: byte not consumed.
  - byte_cnt wraps only via rst.
  - Final word (address 2**ADDR_SIZE-2) must be on the bus in the cycle the cpu presents it; it is.
  - data_bus is never driven when cpu_boot=0, so there is no contention with cpu stores.
  - rst in any state, including mid-LOAD or mid-STREAM: immediately to reset values. cpu_rst=1 from the next edge and the bus is released the same cycle (drive is qualified by state). A partially loaded image is discarded by restarting byte_cnt at 0.
  - rst while rx_valid=1: the byte on that edge is not captured.

Test Plan (ADDR_SIZE=4, IMG_WORDS=8 for speed; loader connected to cpu and a memory model):
- Stream bytes 0x00..0x0F continuously -> rx_ready drops after the 16th byte; cpu_rst high through RELEASE, low the next cycle; memory words at 0,2,..,14 = 0x0100,0x0302,..,0x0F0E; done=1 after cpu boot drops.
- Same image with rx_valid toggling 1/0 each cycle -> identical memory contents; cpu_rst stays 1 until 16 accepted bytes plus 1 cycle.
- Check data_bus each cycle of STREAM -> equals buf[addr_bus>>1]. Check data_bus='bz in LOAD, RELEASE and DONE, and when a cpu STO drives the bus after boot -> no X on bus.
- Assert rst after 9 bytes, then send 16 bytes 0xA0..0xAF -> memory word 0 = 0xA1A0 (old bytes discarded). Assert rst mid-STREAM at addr 6 -> bus 'bz that cycle; cpu_rst=1 next edge; rx_ready=1.
- Tie cpu_boot=0 -> after RELEASE, 2 cycles later err=1, done=1, bus never driven.
- After done, drive rx_valid=1 with 0x55 for 5 cycles -> rx_ready=0; no state change; memory unchanged.
